// File: rtl/bus_pkg.sv
// Shared bus definitions used by the address decoder, masters and slaves.
package bus_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned REGION_W = ADDR_W - OFFSET_W;

  localparam logic [REGION_W-1:0] S0_REGION = 3'b000;
  localparam logic [REGION_W-1:0] S1_REGION = 3'b001;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  // One bus command as seen by a slave.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] din;
  } bus_req_t;

  // Region field of a bus address, as used by the decoder.
  function automatic logic [REGION_W-1:0] region_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/bus_slave_regfile.sv
// DEPTH x DATA_W register file: async-clear, one write port, combinational read port.
module slave_regfile
  import bus_pkg::*;
#(
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned AW    = OFFSET_W,
  parameter int unsigned DEPTH = 2 ** OFFSET_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_c
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/bus_slave.sv
// Memory-mapped bus slave: command decode around a register file with a registered read stage.
module bus_slave
  import bus_pkg::*;
#(
  parameter int unsigned DATA_W   = bus_pkg::DATA_W,
  parameter int unsigned ADDR_W   = bus_pkg::ADDR_W,
  parameter int unsigned OFFSET_W = bus_pkg::OFFSET_W,
  parameter int unsigned DEPTH    = 2 ** OFFSET_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_rvalid
);

  logic [OFFSET_W-1:0] offset;
  logic                wr_en;
  logic                rd_en;
  logic [DATA_W-1:0]   rdata;
  logic                unused_upper;

  assign offset = s_address[OFFSET_W-1:0];
  // Gating by s_sel keeps an undefined s_wr on a deselected bus from touching storage.
  assign wr_en  = s_sel & (s_wr == BUS_WRITE);
  assign rd_en  = s_sel & (s_wr == BUS_READ);

  // Region bits are decoded upstream.
  assign unused_upper = ^s_address[ADDR_W-1:OFFSET_W];

  slave_regfile #(
    .DW    (DATA_W),
    .AW    (OFFSET_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en),
    .waddr   (offset),
    .wdata   (s_din),
    .raddr   (offset),
    .rdata_c (rdata)
  );

  // Read data is zero outside a read so an idle slave adds nothing to the master's mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_dout   <= '0;
      s_rvalid <= 1'b0;
    end else if (rd_en) begin
      s_dout   <= rdata;
      s_rvalid <= 1'b1;
    end else begin
      s_dout   <= '0;
      s_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_slave.sv
// Randomized self-checking bench for bus_slave against an array-based memory model.
module tb_bus_slave;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_address;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        s_rvalid;

  logic [31:0] model [32];
  logic [31:0] exp_dout;
  logic        exp_rvalid;
  int          checks;
  int          errors;

  bus_slave dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_address (s_address),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .s_rvalid  (s_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_dout   = 32'h0;
    exp_rvalid = 1'b0;
  endtask

  // Present one command, let it be sampled, and work out what the slave should show.
  task automatic step(input logic sel, input logic wr, input logic [7:0] addr,
                      input logic [31:0] din);
    int idx;
    s_sel = sel; s_wr = wr; s_address = addr; s_din = din;
    @(posedge clk); #1;
    idx = int'(addr) % 32;
    if (sel && wr) begin
      model[idx] = din;
      exp_dout = 32'h0; exp_rvalid = 1'b0;
    end else if (sel) begin
      exp_dout = model[idx]; exp_rvalid = 1'b1;
    end else begin
      exp_dout = 32'h0; exp_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s_sel = 1'b0; s_wr = 1'b0; s_address = 8'h0; s_din = 32'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h rvalid=%b expected 00000000/0", s_dout, s_rvalid);
    end
    #2 reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h00, 32'h0);
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_read_00: dout=%h rvalid=%b expected 00000000/1", s_dout, s_rvalid);
    end
    step(1'b1, 1'b0, 8'h1F, 32'h0);
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_read_1f: dout=%h rvalid=%b expected 00000000/1", s_dout, s_rvalid);
    end
  endtask

  task automatic test_write_readback();
    step(1'b1, 1'b1, 8'h03, 32'hDEADBEEF);
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL write_cycle: dout=%h rvalid=%b expected 00000000/0", s_dout, s_rvalid);
    end
    step(1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (s_dout !== 32'hDEADBEEF || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL readback_03: dout=%h rvalid=%b expected deadbeef/1", s_dout, s_rvalid);
    end
  endtask

  task automatic test_offset_wrap();
    step(1'b1, 1'b1, 8'h1F, 32'h11111111);
    step(1'b1, 1'b1, 8'h00, 32'h22222222);
    step(1'b1, 1'b0, 8'h1F, 32'h0);
    checks++;
    if (s_dout !== 32'h11111111 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_read_1f: dout=%h rvalid=%b expected 11111111/1", s_dout, s_rvalid);
    end
    step(1'b1, 1'b0, 8'h00, 32'h0);
    checks++;
    if (s_dout !== 32'h22222222 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_read_00: dout=%h rvalid=%b expected 22222222/1", s_dout, s_rvalid);
    end
  endtask

  task automatic test_deselect();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h03, 32'hFFFFFFFF);
      checks++;
      if (s_dout !== 32'h0 || s_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL deselect_idle[%0d]: dout=%h rvalid=%b expected 00000000/0", i, s_dout, s_rvalid);
      end
    end
    step(1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (s_dout !== 32'hDEADBEEF || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL deselect_keep_03: dout=%h rvalid=%b expected deadbeef/1", s_dout, s_rvalid);
    end
  endtask

  task automatic test_upper_bits();
    step(1'b1, 1'b1, 8'h25, 32'hA5A5A5A5);
    step(1'b1, 1'b0, 8'h05, 32'h0);
    checks++;
    if (s_dout !== 32'hA5A5A5A5 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL upper_bits_05: dout=%h rvalid=%b expected a5a5a5a5/1", s_dout, s_rvalid);
    end
  endtask

  task automatic test_random();
    logic       sel, wr;
    logic [7:0] addr;
    for (int i = 0; i < 300; i++) begin
      sel  = ($urandom_range(0, 3) != 0);
      wr   = $urandom_range(0, 1) == 1;
      addr = 8'($urandom);
      step(sel, wr, addr, $urandom);
      checks++;
      if (s_dout !== exp_dout || s_rvalid !== exp_rvalid) begin
        errors++;
        $display("FAIL random[%0d]: dout=%h rvalid=%b expected %h/%b", i, s_dout, s_rvalid,
                 exp_dout, exp_rvalid);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 8'h03, 32'h5A5A1234);
    step(1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (s_dout !== 32'h5A5A1234 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: dout=%h rvalid=%b expected 5a5a1234/1", s_dout, s_rvalid);
    end
    // Asynchronous assertion between edges must clear the output stage at once.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dout=%h rvalid=%b expected 00000000/0", s_dout, s_rvalid);
    end
    clear_model();
    s_sel = 1'b0;
    @(posedge clk); #3 reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h03, 32'h0);
    checks++;
    if (s_dout !== 32'h0 || s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_03: dout=%h rvalid=%b expected 00000000/1", s_dout, s_rvalid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_readback();
    test_offset_wrap();
    test_deselect();
    test_upper_bits();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
